// File: rtl/agex_branch_resolver.sv
// AGEX branch resolver: resolves branches/jumps, redirects FE on mispredict and queues predictor updates.
// Optional BRU_PERF_CNT_EN adds saturating perf counters for branches, mispredicts and dropped updates.
module agex_branch_resolver #(
    parameter int DBITS         = 32,
    parameter int BPBITS        = 8,
    parameter int UQ_DEPTH      = 4,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [2:0]        in_op,
    input  logic [DBITS-1:0]  in_pc,
    input  logic [DBITS-1:0]  in_imm,
    input  logic [DBITS-1:0]  in_rs1,
    input  logic [DBITS-1:0]  in_rs2,
    input  logic [DBITS-1:0]  in_pred_target,
    input  logic [BPBITS-1:0] in_pht_idx,
    output logic              redirect_valid,
    output logic [DBITS-1:0]  redirect_pc,
    output logic              branch_invalid,
    output logic              upd_valid,
    input  logic              upd_ready,
    output logic              upd_dir,
    output logic [BPBITS-1:0] upd_idx,
    output logic [DBITS-1:0]  upd_target,
    output logic [DBITS-1:0]  upd_pc
`ifdef BRU_PERF_CNT_EN
    ,
    output logic [31:0]       perf_branches,
    output logic [31:0]       perf_mispredicts,
    output logic [31:0]       perf_upd_drops
`endif
);

    localparam int AW = $clog2(UQ_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0]    SQ_INIT  = 3'(SQUASH_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(UQ_DEPTH);

    localparam logic [2:0] OP_BEQ  = 3'd0;
    localparam logic [2:0] OP_BNE  = 3'd1;
    localparam logic [2:0] OP_BLT  = 3'd2;
    localparam logic [2:0] OP_BGE  = 3'd3;
    localparam logic [2:0] OP_BLTU = 3'd4;
    localparam logic [2:0] OP_BGEU = 3'd5;
    localparam logic [2:0] OP_JAL  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    typedef enum logic {
        IDLE,
        SQUASH
    } state_t;

    typedef struct packed {
        logic              dir;
        logic [BPBITS-1:0] idx;
        logic [DBITS-1:0]  target;
        logic [DBITS-1:0]  pc;
    } upd_entry_t;

    state_t            state_q, state_d;
    logic [2:0]        sq_cnt_q, sq_cnt_d;
    logic              redirect_valid_q, redirect_valid_d;
    logic [DBITS-1:0]  redirect_pc_q, redirect_pc_d;

    upd_entry_t        mem_q [UQ_DEPTH];
    upd_entry_t        mem_d [UQ_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;

    logic              taken;
    logic [DBITS-1:0]  branch_target;
    logic [DBITS-1:0]  jalr_sum;
    logic [DBITS-1:0]  jalr_target;
    logic [DBITS-1:0]  target;
    logic [DBITS-1:0]  seq_pc;
    logic [DBITS-1:0]  actual_next;
    logic              mispredict;
    logic              accept;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic [AW-1:0]     head_sel;
    upd_entry_t        new_entry;
    upd_entry_t        head;

    // Branch condition and target resolution.
    always_comb begin
        taken = 1'b0;
        case (in_op)
            OP_BEQ:  taken = (in_rs1 == in_rs2);
            OP_BNE:  taken = (in_rs1 != in_rs2);
            OP_BLT:  taken = ($signed(in_rs1) <  $signed(in_rs2));
            OP_BGE:  taken = ($signed(in_rs1) >= $signed(in_rs2));
            OP_BLTU: taken = (in_rs1 <  in_rs2);
            OP_BGEU: taken = (in_rs1 >= in_rs2);
            OP_JAL:  taken = 1'b1;
            OP_JALR: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    assign branch_target = in_pc + in_imm;
    assign jalr_sum      = in_rs1 + in_imm;
    assign jalr_target   = jalr_sum & {{(DBITS-1){1'b1}}, 1'b0};
    assign target        = (in_op == OP_JALR) ? jalr_target : branch_target;
    assign seq_pc        = in_pc + DBITS'(4);
    assign actual_next   = taken ? target : seq_pc;
    assign mispredict    = (actual_next != in_pred_target);

    // Wrong-path instructions arriving during a squash are never accepted.
    assign accept = in_valid && (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            sq_cnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            sq_cnt_q <= sq_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && mispredict) begin
                    state_d  = SQUASH;
                    sq_cnt_d = SQ_INIT;
                end
            end
            SQUASH: begin
                if (sq_cnt_q == 3'd0) begin
                    state_d = IDLE;
                end else begin
                    sq_cnt_d = sq_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d  = IDLE;
                sq_cnt_d = 3'd0;
            end
        endcase
    end

    always_comb begin
        branch_invalid = (state_q == SQUASH);
    end

    // Redirect is a one-cycle pulse; the PC is held afterwards.
    always_comb begin
        redirect_valid_d = accept && mispredict;
        redirect_pc_d    = redirect_pc_q;
        if (accept && mispredict) begin
            redirect_pc_d = actual_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);
    assign pop        = !fifo_empty && upd_ready;
    assign push       = accept && (!fifo_full || pop);
    assign drop       = accept && fifo_full && !pop;
    assign new_entry  = '{dir: taken, idx: in_pht_idx, target: target, pc: in_pc};

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = new_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // When empty, show the most recently popped slot so upd_* keep their last value.
    assign head_sel   = fifo_empty ? (rd_ptr_q - AW'(1)) : rd_ptr_q;
    assign head       = mem_q[head_sel];
    assign upd_valid  = !fifo_empty;
    assign upd_dir    = head.dir;
    assign upd_idx    = head.idx;
    assign upd_target = head.target;
    assign upd_pc     = head.pc;

`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches_q, perf_branches_d;
    logic [31:0] perf_mispredicts_q, perf_mispredicts_d;
    logic [31:0] perf_upd_drops_q, perf_upd_drops_d;

    always_comb begin
        perf_branches_d    = perf_branches_q;
        perf_mispredicts_d = perf_mispredicts_q;
        perf_upd_drops_d   = perf_upd_drops_q;
        if (accept && (perf_branches_q != 32'hFFFF_FFFF)) begin
            perf_branches_d = perf_branches_q + 32'd1;
        end
        if (accept && mispredict && (perf_mispredicts_q != 32'hFFFF_FFFF)) begin
            perf_mispredicts_d = perf_mispredicts_q + 32'd1;
        end
        if (drop && (perf_upd_drops_q != 32'hFFFF_FFFF)) begin
            perf_upd_drops_d = perf_upd_drops_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
            perf_upd_drops_q   <= '0;
        end else begin
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
            perf_upd_drops_q   <= perf_upd_drops_d;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
    assign perf_upd_drops   = perf_upd_drops_q;
`else
    logic unused_drop;
    assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_agex_branch_resolver.sv
// Self-checking bench for agex_branch_resolver: redirect/squash checks inline, predictor updates via a scoreboard queue.
module tb_agex_branch_resolver;

    localparam int DBITS         = 32;
    localparam int BPBITS        = 8;
    localparam int UQ_DEPTH      = 4;
    localparam int SQUASH_CYCLES = 2;

    typedef struct packed {
        logic        dir;
        logic [7:0]  idx;
        logic [31:0] target;
        logic [31:0] pc;
    } upd_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [2:0]  in_op = '0;
    logic [31:0] in_pc = '0, in_imm = '0, in_rs1 = '0, in_rs2 = '0, in_pred_target = '0;
    logic [7:0]  in_pht_idx = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        branch_invalid;
    logic        upd_valid;
    logic        upd_ready = 1'b0;
    logic        upd_dir;
    logic [7:0]  upd_idx;
    logic [31:0] upd_target;
    logic [31:0] upd_pc;
`ifdef BRU_PERF_CNT_EN
    logic [31:0] perf_branches, perf_mispredicts, perf_upd_drops;
`endif

    upd_t exp_q[$];
    upd_t pend_entry;
    bit   pend_valid = 1'b0;
    int   checks = 0;
    int   errors = 0;

    agex_branch_resolver #(
        .DBITS(DBITS), .BPBITS(BPBITS), .UQ_DEPTH(UQ_DEPTH), .SQUASH_CYCLES(SQUASH_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_pc(in_pc),
        .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pred_target(in_pred_target),
        .in_pht_idx(in_pht_idx), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .branch_invalid(branch_invalid), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_dir(upd_dir), .upd_idx(upd_idx), .upd_target(upd_target), .upd_pc(upd_pc)
`ifdef BRU_PERF_CNT_EN
        , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts),
        .perf_upd_drops(perf_upd_drops)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Reference resolution of one branch: direction, taken target and actual next PC.
    function automatic void model(input logic [2:0] op, input logic [31:0] pc, imm, rs1, rs2,
                                  output logic dir, output logic [31:0] tgt, output logic [31:0] nxt);
        case (op)
            3'd0: dir = (rs1 == rs2);
            3'd1: dir = (rs1 != rs2);
            3'd2: dir = ($signed(rs1) < $signed(rs2));
            3'd3: dir = !($signed(rs1) < $signed(rs2));
            3'd4: dir = (rs1 < rs2);
            3'd5: dir = !(rs1 < rs2);
            default: dir = 1'b1;
        endcase
        tgt = (op == 3'd7) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
        nxt = dir ? tgt : (pc + 32'd4);
    endfunction

    // One clock: retire/compare a popped update before the edge, then sample just after it.
    task automatic step();
        upd_t got;
        upd_t want;
        if (reset) begin
            exp_q.delete();
            pend_valid = 1'b0;
        end else begin
            if ((upd_valid === 1'b1) && upd_ready) begin
                got = {upd_dir, upd_idx, upd_target, upd_pc};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL upd_pop got %h required no entry", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        errors++;
                        $display("[TB] FAIL upd_entry got %h required %h", got, want);
                    end
                end
            end
            if (pend_valid && (exp_q.size() < UQ_DEPTH)) exp_q.push_back(pend_entry);
            pend_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        checks++;
        if (upd_valid !== (exp_q.size() != 0)) begin
            errors++;
            $display("[TB] FAIL upd_valid got %b required %b", upd_valid, exp_q.size() != 0);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] pc, imm, rs1, rs2, pred,
                         input logic [7:0] idx, input bit expect_accept);
        logic        dir;
        logic [31:0] tgt, nxt;
        in_valid = 1'b1; in_op = op; in_pc = pc; in_imm = imm;
        in_rs1 = rs1; in_rs2 = rs2; in_pred_target = pred; in_pht_idx = idx;
        model(op, pc, imm, rs1, rs2, dir, tgt, nxt);
        if (expect_accept) begin
            pend_entry = {dir, idx, tgt, pc};
            pend_valid = 1'b1;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks += 4;
        if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rv got %b required 0", redirect_valid); end
        if (redirect_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_rpc got %h required 0", redirect_pc); end
        if (branch_invalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_bi got %b required 0", branch_invalid); end
        if ({upd_dir, upd_idx, upd_target, upd_pc} !== '0) begin errors++; $display("[TB] FAIL reset_upd got %h required 0", upd_pc); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_beq_mispredict();
        upd_ready = 1'b1;
        drive(3'd0, 32'h100, 32'h20, 32'd5, 32'd5, 32'h104, 8'h11, 1'b1);
        checks += 3;
        if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL beq_rv got %b required 1", redirect_valid); end
        if (redirect_pc !== 32'h120) begin errors++; $display("[TB] FAIL beq_rpc got %h required 120", redirect_pc); end
        if (branch_invalid !== 1'b1) begin errors++; $display("[TB] FAIL beq_bi1 got %b required 1", branch_invalid); end
        step();
        checks += 2;
        if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL beq_rv_pulse got %b required 0", redirect_valid); end
        if (branch_invalid !== 1'b1) begin errors++; $display("[TB] FAIL beq_bi2 got %b required 1", branch_invalid); end
        step();
        checks++;
        if (branch_invalid !== 1'b0) begin errors++; $display("[TB] FAIL beq_bi3 got %b required 0", branch_invalid); end
    endtask

    task automatic test_bne_correct();
        drive(3'd1, 32'h100, 32'h40, 32'd7, 32'd7, 32'h104, 8'h22, 1'b1);
        checks += 2;
        if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL bne_rv got %b required 0", redirect_valid); end
        if (branch_invalid !== 1'b0) begin errors++; $display("[TB] FAIL bne_bi got %b required 0", branch_invalid); end
        step();
    endtask

    task automatic test_signed_unsigned();
        drive(3'd2, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 32'h204, 8'h33, 1'b1);
        checks += 2;
        if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL blt_rv got %b required 1", redirect_valid); end
        if (redirect_pc !== 32'h210) begin errors++; $display("[TB] FAIL blt_rpc got %h required 210", redirect_pc); end
        step();
        step();
        drive(3'd4, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, 32'h204, 8'h34, 1'b1);
        checks += 2;
        if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL bltu_rv got %b required 0", redirect_valid); end
        if (branch_invalid !== 1'b0) begin errors++; $display("[TB] FAIL bltu_bi got %b required 0", branch_invalid); end
        step();
    endtask

    task automatic test_jalr_squash();
        drive(3'd7, 32'h400, 32'h0, 32'h203, 32'h0, 32'h300, 8'h44, 1'b1);
        checks += 2;
        if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL jalr_rv got %b required 1", redirect_valid); end
        if (redirect_pc !== 32'h202) begin errors++; $display("[TB] FAIL jalr_rpc got %h required 202", redirect_pc); end
        drive(3'd0, 32'h500, 32'h80, 32'd1, 32'd1, 32'h504, 8'h45, 1'b0);
        checks += 2;
        if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL sq1_rv got %b required 0", redirect_valid); end
        if (branch_invalid !== 1'b1) begin errors++; $display("[TB] FAIL sq1_bi got %b required 1", branch_invalid); end
        drive(3'd1, 32'h600, 32'h80, 32'd1, 32'd2, 32'h604, 8'h46, 1'b0);
        checks += 2;
        if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL sq2_rv got %b required 0", redirect_valid); end
        if (branch_invalid !== 1'b0) begin errors++; $display("[TB] FAIL sq2_bi got %b required 0", branch_invalid); end
        step();
        step();
    endtask

    task automatic test_fifo_full();
        logic        d;
        logic [31:0] t, n, pc, imm, rs1;
        upd_ready = 1'b1;
        step();
        step();
        upd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pc  = 32'h800 + 32'(i) * 32'h10;
            imm = 32'h40 + 32'(i) * 32'd4;
            rs1 = 32'(i);
            model(3'(i), pc, imm, rs1, 32'd3, d, t, n);
            drive(3'(i), pc, imm, rs1, 32'd3, n, 8'(8'h50 + i), 1'b1);
            checks++;
            if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_rv%0d got %b required 0", i, redirect_valid); end
        end
        upd_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc = 32'hC00 + 32'(i) * 32'h8;
            model(3'd5, pc, 32'h20, 32'd9, 32'(i * 4), d, t, n);
            drive(3'd5, pc, 32'h20, 32'd9, 32'(i * 4), n, 8'(8'h60 + i), 1'b1);
        end
        upd_ready = 1'b1;
        drive(3'd6, 32'h900, 32'h100, 32'h0, 32'h0, 32'hA00, 8'h70, 1'b1);
        checks++;
        if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL full_pushpop_rv got %b required 0", redirect_valid); end
        for (int i = 0; i < 5; i++) step();
    endtask

    task automatic test_reset_mid_squash();
        upd_ready = 1'b0;
        drive(3'd0, 32'hA00, 32'h8, 32'd1, 32'd2, 32'hA04, 8'h80, 1'b1);
        drive(3'd6, 32'hA10, 32'h40, 32'd0, 32'd0, 32'hA50, 8'h81, 1'b1);
        drive(3'd0, 32'hA20, 32'h8, 32'd3, 32'd3, 32'hA24, 8'h82, 1'b1);
        checks++;
        if (branch_invalid !== 1'b1) begin errors++; $display("[TB] FAIL rsq_bi_pre got %b required 1", branch_invalid); end
        reset = 1'b1;
        step();
        checks += 3;
        if (branch_invalid !== 1'b0) begin errors++; $display("[TB] FAIL rsq_bi got %b required 0", branch_invalid); end
        if (upd_valid !== 1'b0) begin errors++; $display("[TB] FAIL rsq_uv got %b required 0", upd_valid); end
        if (redirect_valid !== 1'b0) begin errors++; $display("[TB] FAIL rsq_rv got %b required 0", redirect_valid); end
        reset = 1'b0;
        upd_ready = 1'b1;
        drive(3'd1, 32'hB00, 32'h20, 32'd1, 32'd2, 32'hB04, 8'h90, 1'b1);
        checks += 3;
        if (redirect_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_rv got %b required 1", redirect_valid); end
        if (redirect_pc !== 32'hB20) begin errors++; $display("[TB] FAIL post_rpc got %h required b20", redirect_pc); end
        if (branch_invalid !== 1'b1) begin errors++; $display("[TB] FAIL post_bi1 got %b required 1", branch_invalid); end
        step();
        checks++;
        if (branch_invalid !== 1'b1) begin errors++; $display("[TB] FAIL post_bi2 got %b required 1", branch_invalid); end
        step();
        checks++;
        if (branch_invalid !== 1'b0) begin errors++; $display("[TB] FAIL post_bi3 got %b required 0", branch_invalid); end
        step();
    endtask

    initial begin
        test_reset();
        test_beq_mispredict();
        test_bne_correct();
        test_signed_unsigned();
        test_jalr_squash();
        test_fifo_full();
        test_reset_mid_squash();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/agex_branch_resolver.md
Name: agex_branch_resolver

Overview:
- Sits in the AGEX stage and is the resolving end of the branch-prediction protocol.
- Evaluates each branch or jump arriving from the DE latch and compares the actual next PC against the predicted target carried with the instruction.
- On a mispredict, drives the FE redirect and the DE/AGEX squash (branch_invalid).
- Queues predictor training updates (direction, PHT index, target, PC) in a small FIFO. The FIFO drains to the branch predictor over a valid/ready handshake.

Parameters:
- DBITS, 32, data/address width.
- BPBITS, 8, PHT index width.
- UQ_DEPTH, 4, update FIFO entries (power of 2, >=2).
- SQUASH_CYCLES, 2, cycles branch_invalid is held after a mispredict (1..7).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  branch/jump instruction present in AGEX this cycle
- in_op  in  3  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 JAL, 7 JALR
- in_pc  in  DBITS  PC of instruction
- in_imm  in  DBITS  sign-extended immediate
- in_rs1  in  DBITS  rs1 value
- in_rs2  in  DBITS  rs2 value
- in_pred_target  in  DBITS  next PC predicted at fetch
- in_pht_idx  in  BPBITS  PHT index used at prediction
- redirect_valid  out  1  FE must load redirect_pc
- redirect_pc  out  DBITS  correct next PC
- branch_invalid  out  1  squash DE latch / AGEX input
- upd_valid  out  1  FIFO head valid
- upd_ready  in  1  predictor accepts head
- upd_dir  out  1  actual direction (1 = taken)
- upd_idx  out  BPBITS  PHT index
- upd_target  out  DBITS  actual taken target
- upd_pc  out  DBITS  branch PC

Behaviour:
- Reset: all outputs 0, FSM IDLE, FIFO empty, squash counter 0. Reset mid-squash or with a non-empty FIFO discards everything.
- Taken rules:
  - BEQ/BNE use equality.
  - BLT/BGE use signed compare.
  - BLTU/BGEU use unsigned compare.
  - JAL/JALR are always taken.
- Taken target:
  - in_pc+in_imm for branches and JAL.
  - (in_rs1+in_imm) with bit0 cleared for JALR.
  - All arithmetic is modulo 2^DBITS.
- actual_next = taken ? target : in_pc+4.
- Mispredict: actual_next != in_pred_target.
- Accept condition: an instruction is accepted only when in_valid=1 and the FSM is in IDLE.
- FSM IDLE:
  - On an accepted mispredict, the next cycle asserts redirect_valid=1 for exactly one cycle, with redirect_pc=actual_next.
  - branch_invalid=1 from that same cycle.
  - FSM moves to SQUASH with counter = SQUASH_CYCLES-1.
- FSM SQUASH:
  - branch_invalid stays 1; in_valid is ignored (wrong path).
  - Counter decrements each cycle; when it reaches 0, the FSM returns to IDLE after that cycle.
  - branch_invalid is high for exactly SQUASH_CYCLES consecutive cycles.
- Correct prediction: no redirect and no squash; the FSM stays in IDLE.
- Update push:
  - Every accepted instruction pushes {dir, idx, target, pc} in its acceptance cycle. target is the taken target even when the branch is not taken.
  - JAL/JALR push dir=1.
  - The entry is visible on upd_* the following cycle.
- Update pop: occurs when upd_valid && upd_ready.
- FIFO full:
  - A push with no simultaneous pop is dropped silently; the FIFO is unchanged.
  - A push and pop in the same cycle while full both succeed.
- FIFO empty: upd_valid=0; upd_* hold their last value, and the verifier must not check them.
- Order: FIFO is strictly first-in first-out; pointers wrap modulo UQ_DEPTH.
- Latency: redirect and branch_invalid 1 cycle after acceptance; FIFO output 1 cycle after push.

Optional Feature:
- BRU_PERF_CNT_EN:
  - When defined, adds three 32-bit counters, cleared on reset and saturating at 0xFFFFFFFF:
    - perf_branches: accepted instructions.
    - perf_mispredicts: accepted mispredicts.
    - perf_upd_drops: dropped pushes.
  - The counters are output ports of width 32.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- BEQ, pc=0x100, imm=0x20, rs1=rs2=5, pred=0x104 -> next cycle redirect_valid=1, redirect_pc=0x120; branch_invalid high 2 cycles; upd: dir=1, target=0x120, pc=0x100.
- BNE, rs1=rs2, pred=0x104 (pc=0x100) -> no redirect, branch_invalid=0; upd dir=0, target=pc+imm.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU with the same operands -> not taken. Each checked against pred to give the expected redirect / no redirect.
- JALR rs1=0x203, imm=0, pred=0x300 -> redirect_pc=0x202. A second in_valid during the next 2 cycles -> ignored: no upd push, no redirect.
- upd_ready=0, 6 correct-prediction branches -> first 4 retained in order, last 2 dropped. Then upd_ready=1 -> 4 pops in order, upd_valid falls after the 4th.
- Reset asserted in the first SQUASH cycle with 3 FIFO entries -> next cycle branch_invalid=0, upd_valid=0, redirect_valid=0. A following mispredict behaves normally.
